// File: rtl/mem_arbiter_pkg.sv
// Shared types, constants and helpers for the I/D main-memory arbiter.
// Holds the FSM state and owner-tag encodings plus the bank-index bit positions.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NBANK    = 4;
    localparam int unsigned BANK_LSB = 1;
    localparam int unsigned BANK_MSB = 2;
    localparam int unsigned BANK_W   = BANK_MSB - BANK_LSB + 1;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_I    = 2'd1,
        TAG_D    = 2'd2
    } owner_tag_e;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              lock;
    } req_t;

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[BANK_MSB:BANK_LSB];
    endfunction

    // Exactly one of rd/wr, memory not stalled and the target bank idle.
    function automatic logic req_ok(input req_t r, input logic [NBANK-1:0] busy,
                                    input logic stall);
        return (r.rd ^ r.wr) & ~stall & ~busy[bank_of(r.addr)];
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// slave = the arbiter's view; master = the environment (caches + memory) view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              i_rd, i_wr, i_lock, i_grant, i_stall, i_rvalid;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;

    logic              d_rd, d_wr, d_lock, d_grant, d_stall, d_rvalid;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;

    logic [DATA_W-1:0] rdata;

    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [NBANK-1:0]  mem_busy;
    logic              mem_stall, mem_err, err;

    modport slave (
        input  i_rd, i_wr, i_addr, i_wdata, i_lock,
        input  d_rd, d_wr, d_addr, d_wdata, d_lock,
        input  mem_rdata, mem_busy, mem_stall, mem_err,
        output i_grant, i_stall, i_rvalid,
        output d_grant, d_stall, d_rvalid,
        output rdata, mem_rd, mem_wr, mem_addr, mem_wdata, err
    );

    modport master (
        output i_rd, i_wr, i_addr, i_wdata, i_lock,
        output d_rd, d_wr, d_addr, d_wdata, d_lock,
        output mem_rdata, mem_busy, mem_stall, mem_err,
        input  i_grant, i_stall, i_rvalid,
        input  d_grant, d_stall, d_rvalid,
        input  rdata, mem_rd, mem_wr, mem_addr, mem_wdata, err
    );

endinterface

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register of read-owner tags; the tail names who gets the returning data.
module mem_arbiter_rd_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  owner_tag_e tag_in,
    output owner_tag_e tag_out
);

    owner_tag_e stage_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < RD_LAT; k++) stage_q[k] <= TAG_NONE;
        end else begin
            stage_q[0] <= tag_in;
            for (int unsigned k = 1; k < RD_LAT; k++) stage_q[k] <= stage_q[k-1];
        end
    end

    assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I and D cache controllers onto one four-banked memory, one access per cycle.
// Build option MEM_ARB_DFIRST_EN: fixed D-over-I priority in ARB instead of round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    req_t              i_r, d_r;
    logic              i_req, d_req, i_ill, d_ill, i_ok, d_ok;
    logic              arb_i, arb_d, hold_i, hold_d;
    logic              gnt_i, gnt_d;
    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, mem_addr_c;
    logic [DATA_W-1:0] wdata_q, mem_wdata_c;
    owner_tag_e        tag_push, tag_tail;

    assign i_r = '{rd: bus.i_rd, wr: bus.i_wr, addr: bus.i_addr, wdata: bus.i_wdata, lock: bus.i_lock};
    assign d_r = '{rd: bus.d_rd, wr: bus.d_wr, addr: bus.d_addr, wdata: bus.d_wdata, lock: bus.d_lock};

    assign i_req = i_r.rd | i_r.wr;
    assign d_req = d_r.rd | d_r.wr;
    assign i_ill = i_r.rd & i_r.wr;
    assign d_ill = d_r.rd & d_r.wr;
    assign i_ok  = req_ok(i_r, bus.mem_busy, bus.mem_stall);
    assign d_ok  = req_ok(d_r, bus.mem_busy, bus.mem_stall);

`ifdef MEM_ARB_DFIRST_EN
    assign arb_d = d_ok;
    assign arb_i = i_ok & ~d_ok;
`else
    logic ptr_d_q;  // 1: D wins the next tie

    assign arb_i = i_ok & (~d_ok | ~ptr_d_q);
    assign arb_d = d_ok & (~i_ok | ptr_d_q);

    always_ff @(posedge clk) begin
        if (rst)                ptr_d_q <= 1'b0;
        else if (gnt_i | gnt_d) ptr_d_q <= gnt_i;
    end
`endif

    // The owner keeps memory only while its lock stays high; lock low arbitrates normally.
    assign hold_i = (state_q == LOCK_I) && i_r.lock;
    assign hold_d = (state_q == LOCK_D) && d_r.lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= mem_addr_c;
            wdata_q <= mem_wdata_c;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        if (hold_i) begin
            gnt_i = i_ok;
        end else if (hold_d) begin
            gnt_d = d_ok;
        end else begin
            gnt_i   = arb_i;
            gnt_d   = arb_d;
            state_d = ARB;
            if (gnt_i && i_r.lock)      state_d = LOCK_I;
            else if (gnt_d && d_r.lock) state_d = LOCK_D;
        end
        if (rst) begin
            gnt_i = 1'b0;
            gnt_d = 1'b0;
        end
    end

    // Memory bus follows the winner; address/data hold their last value when idle.
    always_comb begin
        mem_addr_c  = addr_q;
        mem_wdata_c = wdata_q;
        tag_push    = TAG_NONE;
        if (gnt_i) begin
            mem_addr_c  = i_r.addr;
            mem_wdata_c = i_r.wdata;
            if (i_r.rd) tag_push = TAG_I;
        end else if (gnt_d) begin
            mem_addr_c  = d_r.addr;
            mem_wdata_c = d_r.wdata;
            if (d_r.rd) tag_push = TAG_D;
        end
        if (rst) begin
            mem_addr_c  = '0;
            mem_wdata_c = '0;
        end
    end

    mem_arbiter_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_push),
        .tag_out (tag_tail)
    );

    assign bus.i_grant   = gnt_i;
    assign bus.d_grant   = gnt_d;
    assign bus.i_stall   = ~rst & i_req & ~gnt_i;
    assign bus.d_stall   = ~rst & d_req & ~gnt_d;
    assign bus.mem_rd    = (gnt_i & i_r.rd) | (gnt_d & d_r.rd);
    assign bus.mem_wr    = (gnt_i & i_r.wr) | (gnt_d & d_r.wr);
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.i_rvalid  = ~rst & (tag_tail == TAG_I);
    assign bus.d_rvalid  = ~rst & (tag_tail == TAG_D);
    assign bus.rdata     = rst ? '0 : bus.mem_rdata;
    assign bus.err       = ~rst & (bus.mem_err | i_ill | d_ill);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then random traffic against a cycle-level model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned LAT = 2;

    typedef struct {
        int          cyc;
        logic        in_rst;
        logic        i_grant, d_grant, i_stall, d_stall, i_rvalid, d_rvalid;
        logic        err, mem_rd, mem_wr;
        logic [15:0] mem_addr, mem_wdata, rdata;
    } exp_t;

    typedef struct {
        int          due;
        bit          to_d;
        logic [15:0] data;
    } ret_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.RD_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL timeout cycle %0d", cyc);
        $fatal(1);
    end

    // Memory device: fixed-latency reads, contents re-seeded on reset.
    logic [15:0] dev_mem  [64];
    logic [15:0] dev_pipe [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 64; a++) dev_mem[a] <= 16'(a * 16'h0101) ^ 16'h3c5a;
        end else if (bus.mem_wr) begin
            dev_mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
        for (int k = LAT - 1; k > 0; k--) dev_pipe[k] <= dev_pipe[k-1];
        dev_pipe[0] <= bus.mem_rd ? dev_mem[bus.mem_addr[5:0]] : 16'hdead;
    end
    assign bus.mem_rdata = dev_pipe[LAT-1];

    // Reference model state
    exp_t        exp_q [$];
    ret_t        ret_q [$];
    logic [15:0] mdl_mem [64];
    int          m_owner = 0;   // 0 none, 1 I, 2 D
    bit          m_ptr_d = 1'b0;
    logic [15:0] m_last_addr = '0;
    logic [15:0] m_last_wdata = '0;

    function automatic void chk(string nm, int cy, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cy, act, expv);
        end
    endfunction

    function automatic req_t mk(logic rd, logic wr, logic [15:0] addr, logic [15:0] wdata, logic lock);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata; r.lock = lock;
        return r;
    endfunction

    function automatic req_t rand_req();
        int k;
        k = $urandom_range(0, 99);
        return mk(k < 40 || k >= 97, (k >= 40 && k < 60) || k >= 97,
                  16'($urandom_range(0, 63)), 16'($urandom), $urandom_range(0, 99) < 30);
    endfunction

    // Apply one cycle of inputs and push the model's prediction for that cycle.
    task automatic step(input logic r, input req_t ir, input req_t dr,
                        input logic [3:0] busy, input logic stall, input logic merr);
        exp_t e;
        ret_t rt;
        req_t w;
        bit   i_want, d_want, i_bad, d_bad, i_can, d_can;
        int   pick;
        @(posedge clk);
        #1;
        rst = r;
        bus.i_rd = ir.rd; bus.i_wr = ir.wr; bus.i_addr = ir.addr; bus.i_wdata = ir.wdata; bus.i_lock = ir.lock;
        bus.d_rd = dr.rd; bus.d_wr = dr.wr; bus.d_addr = dr.addr; bus.d_wdata = dr.wdata; bus.d_lock = dr.lock;
        bus.mem_busy = busy; bus.mem_stall = stall; bus.mem_err = merr;

        e = '{cyc: cyc, in_rst: r, default: '0};
        if (r) begin
            ret_q.delete();
            m_owner = 0; m_ptr_d = 1'b0; m_last_addr = '0; m_last_wdata = '0;
            for (int a = 0; a < 64; a++) mdl_mem[a] = 16'(a * 16'h0101) ^ 16'h3c5a;
        end else begin
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                rt = ret_q.pop_front();
                if (rt.to_d) e.d_rvalid = 1'b1; else e.i_rvalid = 1'b1;
                e.rdata = rt.data;
            end
            i_want = ir.rd | ir.wr;  d_want = dr.rd | dr.wr;
            i_bad  = ir.rd & ir.wr;  d_bad  = dr.rd & dr.wr;
            i_can  = i_want && !i_bad && !stall && !busy[ir.addr[2:1]];
            d_can  = d_want && !d_bad && !stall && !busy[dr.addr[2:1]];
            e.err  = merr | i_bad | d_bad;

            if (m_owner == 1 && ir.lock) begin
                pick = i_can ? 1 : 0;
            end else if (m_owner == 2 && dr.lock) begin
                pick = d_can ? 2 : 0;
            end else begin
                if (i_can && d_can) begin
`ifdef MEM_ARB_DFIRST_EN
                    pick = 2;
`else
                    pick = m_ptr_d ? 2 : 1;
`endif
                end else begin
                    pick = i_can ? 1 : (d_can ? 2 : 0);
                end
                m_owner = 0;
                if (pick == 1 && ir.lock) m_owner = 1;
                if (pick == 2 && dr.lock) m_owner = 2;
            end

            if (pick != 0) begin
                w = (pick == 1) ? ir : dr;
                e.mem_rd = w.rd; e.mem_wr = w.wr;
                m_last_addr = w.addr; m_last_wdata = w.wdata;
                m_ptr_d = (pick == 1);
                if (w.rd) begin
                    rt.due = cyc + LAT; rt.to_d = (pick == 2); rt.data = mdl_mem[w.addr[5:0]];
                    ret_q.push_back(rt);
                end
                if (w.wr) mdl_mem[w.addr[5:0]] = w.wdata;
            end
            e.i_grant = (pick == 1); e.d_grant = (pick == 2);
            e.i_stall = i_want && pick != 1;
            e.d_stall = d_want && pick != 2;
            e.mem_addr = m_last_addr; e.mem_wdata = m_last_wdata;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic r);
        for (int k = 0; k < n; k++) step(r, '0, '0, 4'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one prediction per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle_tag", cyc, 32'(cyc), 32'(e.cyc));
            chk("i_grant",  e.cyc, 32'(bus.i_grant),  32'(e.i_grant));
            chk("d_grant",  e.cyc, 32'(bus.d_grant),  32'(e.d_grant));
            chk("i_stall",  e.cyc, 32'(bus.i_stall),  32'(e.i_stall));
            chk("d_stall",  e.cyc, 32'(bus.d_stall),  32'(e.d_stall));
            chk("i_rvalid", e.cyc, 32'(bus.i_rvalid), 32'(e.i_rvalid));
            chk("d_rvalid", e.cyc, 32'(bus.d_rvalid), 32'(e.d_rvalid));
            chk("err",      e.cyc, 32'(bus.err),      32'(e.err));
            chk("mem_rd",   e.cyc, 32'(bus.mem_rd),   32'(e.mem_rd));
            chk("mem_wr",   e.cyc, 32'(bus.mem_wr),   32'(e.mem_wr));
            chk("mem_addr", e.cyc, 32'(bus.mem_addr), 32'(e.mem_addr));
            chk("mem_wdata", e.cyc, 32'(bus.mem_wdata), 32'(e.mem_wdata));
            if (e.i_rvalid || e.d_rvalid || e.in_rst)
                chk("rdata", e.cyc, 32'(bus.rdata), 32'(e.rdata));
        end
    end

    initial begin
        bus.i_rd = 0; bus.i_wr = 0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_lock = 0;
        bus.d_rd = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_lock = 0;
        bus.mem_busy = '0; bus.mem_stall = 0; bus.mem_err = 0;

        idle(2, 1'b1);

        // Single I read on idle memory
        step(0, mk(1, 0, 16'h0010, 0, 0), '0, 4'b0, 0, 0);
        idle(LAT + 1, 1'b0);

        // Simultaneous I/D reads with the pointer at I after reset
        idle(1, 1'b1);
        step(0, mk(1, 0, 16'h0000, 0, 0), mk(1, 0, 16'h0002, 0, 0), 4'b0, 0, 0);
`ifdef MEM_ARB_DFIRST_EN
        step(0, mk(1, 0, 16'h0000, 0, 0), '0, 4'b0, 0, 0);
`else
        step(0, '0, mk(1, 0, 16'h0002, 0, 0), 4'b0, 0, 0);
`endif
        idle(LAT + 1, 1'b0);

        // Busy bank 0 blocks D while I targets bank 2
        step(0, mk(1, 0, 16'h0004, 0, 0), mk(1, 0, 16'h0000, 0, 0), 4'b0001, 0, 0);
        step(0, '0, mk(1, 0, 16'h0000, 0, 0), 4'b0001, 0, 0);
        step(0, '0, mk(1, 0, 16'h0000, 0, 0), 4'b0000, 0, 0);
        idle(LAT + 1, 1'b0);

        // D line fill under lock while I requests throughout
        step(0, '0, mk(1, 0, 16'h0100, 0, 1), 4'b0, 0, 0);
        for (int w = 1; w < 4; w++)
            step(0, mk(1, 0, 16'h0020, 0, 0), mk(1, 0, 16'(16'h0100 + 2 * w), 0, 1), 4'b0, 0, 0);
        step(0, mk(1, 0, 16'h0020, 0, 0), '0, 4'b0, 0, 0);
        idle(LAT + 1, 1'b0);

        // Illegal D request, then a memory error
        step(0, '0, mk(1, 1, 16'h0008, 16'h1234, 0), 4'b0, 0, 0);
        step(0, '0, '0, 4'b0, 0, 1);

        // Reset one cycle after an I read issue
        step(0, mk(1, 0, 16'h0030, 0, 0), '0, 4'b0, 0, 0);
        idle(1, 1'b1);
        idle(LAT + 2, 1'b0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] busy;
            for (int b = 0; b < 4; b++) busy[b] = ($urandom_range(0, 99) < 15);
            step($urandom_range(0, 199) == 0, rand_req(), rand_req(), busy,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3);
        end
        idle(LAT + 2, 1'b0);

        @(negedge clk);
        #1;
        chk("drain", cyc, 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
